mux_scan_nx1: RTL and testbench

MUX_SCAN_NX1 -- requirements
Module: mux_scan_nx1

---
 rtl/mux_scan_nx1.sv | 92 +++++++++
 tb/tb_mux_scan_nx1.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nx1.sv
// N:1 registered channel multiplexer with direct, scan, round-robin and hold modes.
// Valid/ready handshake on both sides; one cycle from input channel to y.
module mux_scan_nx1 #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0][WIDTH-1:0]   i,
    input  logic [CHANNELS-1:0]              i_valid,
    output logic [CHANNELS-1:0]              i_ready,
    input  logic [1:0]                       mode,
    input  logic [SEL_W-1:0]                 s,
    output logic [WIDTH-1:0]                 y,
    output logic [SEL_W-1:0]                 y_ch,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             sel_err
);

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_SCAN   = 2'b01;
    localparam logic [1:0] M_RR     = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] scan_ptr, rr_last, rr_c, c, cs;
    logic             rr_hit, c_ok, load, xfer, bad_sel;

    assign load = (!out_valid || out_ready) && (mode != M_HOLD);

    // Cyclic search from rr_last+1; iterating downwards lets the nearest hit win.
    always_comb begin
        int j;
        j      = 0;
        rr_hit = 1'b0;
        rr_c   = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            j = (int'(rr_last) + k) % CHANNELS;
            if (i_valid[j]) begin
                rr_hit = 1'b1;
                rr_c   = SEL_W'(j);
            end
        end
    end

    always_comb begin
        c    = '0;
        c_ok = 1'b0;
        case (mode)
            M_DIRECT: begin c = s;        c_ok = (int'(s) < CHANNELS); end
            M_SCAN:   begin c = scan_ptr; c_ok = 1'b1;                 end
            M_RR:     begin c = rr_c;     c_ok = rr_hit;               end
            default:  begin c = '0;       c_ok = 1'b0;                 end
        endcase
    end

    assign cs      = c_ok ? c : '0;
    assign xfer    = load && c_ok && i_valid[cs];
    assign bad_sel = load && (mode == M_DIRECT) && !c_ok;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_rdy
        assign i_ready[g] = xfer && (cs == SEL_W'(g));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y         <= '0;
            y_ch      <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            scan_ptr  <= '0;
            rr_last   <= LAST;
        end else begin
            sel_err <= bad_sel;
            if (xfer) begin
                y         <= i[cs];
                y_ch      <= cs;
                out_valid <= 1'b1;
            end else if (!out_valid || out_ready) begin
                // Empty slot or drain (including hold mode): data already left downstream.
                out_valid <= 1'b0;
            end
            if (load && mode == M_SCAN)
                scan_ptr <= (scan_ptr == LAST) ? '0 : scan_ptr + 1'b1;
            if (xfer && mode == M_RR)
                rr_last <= cs;
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Randomized + directed bench for mux_scan_nx1: a 16-channel and a 12-channel
// instance share stimulus and are checked each cycle against a behavioural model.
module tb_mux_scan_nx1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [15:0][31:0] din;
    logic [15:0]       iv;
    logic [1:0]        md;
    logic [3:0]        sel;
    logic              ordy;

    logic [15:0] rdy16;
    logic [31:0] y16;
    logic [3:0]  ych16;
    logic        ov16, se16;
    logic [11:0] rdy12;
    logic [31:0] y12;
    logic [3:0]  ych12;
    logic        ov12, se12;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        ov;
        logic [31:0] y;
        int          ych;
        logic        se;
        int          scan;
        int          rr;
    } mdl_t;

    mdl_t m16, m12;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.WIDTH(32), .CHANNELS(16)) dut16 (
        .clk(clk), .rst(rst), .i(din), .i_valid(iv), .i_ready(rdy16),
        .mode(md), .s(sel), .y(y16), .y_ch(ych16), .out_valid(ov16),
        .out_ready(ordy), .sel_err(se16)
    );

    mux_scan_nx1 #(.WIDTH(32), .CHANNELS(12)) dut12 (
        .clk(clk), .rst(rst), .i(din[11:0]), .i_valid(iv[11:0]), .i_ready(rdy12),
        .mode(md), .s(sel), .y(y12), .y_ch(ych12), .out_valid(ov12),
        .out_ready(ordy), .sel_err(se12)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mreset(input int ch);
        mdl_t m;
        m.ov = 0; m.y = 0; m.ych = 0; m.se = 0; m.scan = 0; m.rr = ch - 1;
        return m;
    endfunction

    // One clock of the reference behaviour for a ch-channel build.
    task automatic mstep(input int ch, input mdl_t m, output mdl_t nm, output logic [63:0] rdy);
        bit load, xfer;
        int cand;
        load = (!m.ov || ordy) && md != 2'd3;
        cand = -1;
        case (md)
            2'd0: if (int'(sel) < ch) cand = int'(sel);
            2'd1: cand = m.scan;
            2'd2: for (int k = 1; k <= ch; k++)
                      if (cand < 0 && iv[(m.rr + k) % ch]) cand = (m.rr + k) % ch;
            default: cand = -1;
        endcase
        xfer = load && cand >= 0 && iv[cand];
        rdy  = xfer ? (64'd1 << cand) : 64'd0;
        nm    = m;
        nm.se = load && md == 2'd0 && int'(sel) >= ch;
        if (xfer) begin
            nm.ov = 1; nm.y = din[cand]; nm.ych = cand;
        end else if (!m.ov || ordy) begin
            nm.ov = 0;
        end
        if (load && md == 2'd1) nm.scan = (m.scan + 1) % ch;
        if (xfer && md == 2'd2) nm.rr = cand;
    endtask

    task automatic chk_out();
        chk("y16",   64'(y16),   64'(m16.y));
        chk("ov16",  64'(ov16),  64'(m16.ov));
        chk("ych16", 64'(ych16), 64'(m16.ych));
        chk("se16",  64'(se16),  64'(m16.se));
        chk("y12",   64'(y12),   64'(m12.y));
        chk("ov12",  64'(ov12),  64'(m12.ov));
        chk("ych12", 64'(ych12), 64'(m12.ych));
        chk("se12",  64'(se12),  64'(m12.se));
    endtask

    // Caller sets inputs at a negedge; this checks i_ready, clocks once, checks outputs.
    task automatic step();
        mdl_t n16, n12;
        logic [63:0] r16, r12;
        #1;
        mstep(16, m16, n16, r16);
        mstep(12, m12, n12, r12);
        chk("rdy16", 64'(rdy16), r16);
        chk("rdy12", 64'(rdy12), r12);
        @(posedge clk);
        m16 = n16;
        m12 = n12;
        @(negedge clk);
        chk_out();
    endtask

    task automatic rnd_din();
        for (int k = 0; k < 16; k++) din[k] = $urandom;
    endtask

    initial begin
        rnd_din();
        iv = '0; md = 2'd0; sel = '0; ordy = 1'b1;
        m16 = mreset(16);
        m12 = mreset(12);
        #2;
        chk_out();
        chk("rst_ov", 64'(ov16), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Direct capture then backpressure.
        md = 2'd0; sel = 4'd5; din[5] = 32'hDEADBEEF; iv = 16'hFFFF; ordy = 1'b1;
        step();
        chk("dead_y", 64'(y16), 64'hDEADBEEF);
        chk("dead_ch", 64'(ych16), 64'd5);
        ordy = 1'b0; din[5] = 32'h1;
        repeat (3) step();
        chk("bp_hold", 64'(y16), 64'hDEADBEEF);
        ordy = 1'b1;
        step();
        chk("bp_load", 64'(y16), 64'h1);

        // Scan with sparse valids, long enough to wrap both builds.
        md = 2'd1; iv = 16'h0005;
        repeat (20) begin rnd_din(); step(); end

        // Round-robin alternation, then idle, then resume.
        md = 2'd2; iv = 16'h8001;
        repeat (6) begin rnd_din(); step(); end
        iv = 16'h0000;
        repeat (2) step();
        iv = 16'h8001;
        repeat (3) step();

        // Out-of-range direct select on the 12-channel build.
        md = 2'd0; sel = 4'd13; iv = 16'hFFFF;
        step();
        chk("selerr12", 64'(se12), 64'd1);
        chk("selerr_ov12", 64'(ov12), 64'd0);
        sel = 4'd2;
        step();
        chk("selerr12_clr", 64'(se12), 64'd0);

        // Hold mode with backpressure then drain.
        md = 2'd3; ordy = 1'b0;
        repeat (2) step();
        ordy = 1'b1;
        repeat (2) step();

        // Random traffic.
        repeat (400) begin
            rnd_din();
            md   = 2'($urandom_range(0, 3));
            sel  = 4'($urandom);
            iv   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset asserted between edges with data in flight.
        md = 2'd0; sel = 4'd1; iv = 16'hFFFF; ordy = 1'b0;
        step();
        #3 rst = 1'b0;
        #1;
        m16 = mreset(16);
        m12 = mreset(12);
        chk_out();
        @(negedge clk);
        rst = 1'b1;
        md = 2'd2; iv = 16'hFFFF; ordy = 1'b1;
        step();
        chk("rr_first", 64'(ych16), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
